tri_monitor: RTL and testbench

Receive-side checker for the 4-bit triangle-wave counter stream (0→15→0 with a one-sample hold at each extremum). Samples the counter value, tracks ramp direction and phase, and flags any sample that breaks the pattern. Reports peak and trough events and the measured period. Sits beside the generator as a self-check and feeds status to the top-level debug outputs.

---
 rtl/tri_pkg.sv | 23 ++
 rtl/tri_step_classify.sv | 32 +++
 rtl/tri_monitor.sv | 224 ++++++++++++++++++++++
 tb/tb_tri_monitor.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tri_pkg.sv
// rtl/tri_pkg.sv - shared types and defaults for the triangle-stream monitor
package tri_pkg;

   localparam int TRI_W      = 4;
   localparam int TRI_LOCK_N = 4;
   localparam int TRI_PW     = TRI_W + 3;

   typedef enum logic [2:0] {
      SYNC,
      UP,
      HOLD_TOP,
      DOWN,
      HOLD_BOT
   } tri_state_t;

   typedef enum logic [1:0] {
      INC,
      DEC,
      HOLD,
      BAD
   } tri_step_t;

endpackage

// File: rtl/tri_step_classify.sv
// rtl/tri_step_classify.sv - classify one sample step against the previous sample
module tri_step_classify
   import tri_pkg::*;
#(
   parameter int W = TRI_W
) (
   input  logic [W-1:0] p,
   input  logic [W-1:0] s,
   output tri_step_t    step
);

   localparam logic [W:0] ONE = (W+1)'(1);

   logic [W:0] p_ext;
   logic [W:0] s_ext;

   // One extra bit keeps MAX+1 and 0-1 out of range, so wrap jumps land in BAD.
   always_comb begin
      p_ext = {1'b0, p};
      s_ext = {1'b0, s};
      if (s_ext == p_ext + ONE) begin
         step = INC;
      end else if (s_ext + ONE == p_ext) begin
         step = DEC;
      end else if (s_ext == p_ext) begin
         step = HOLD;
      end else begin
         step = BAD;
      end
   end

endmodule

// File: rtl/tri_monitor.sv
// rtl/tri_monitor.sv - receive-side checker for the triangle counter stream
module tri_monitor
   import tri_pkg::*;
#(
   parameter int W      = TRI_W,
   parameter int LOCK_N = TRI_LOCK_N,
   parameter int PW     = W + 3
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          en,
   input  logic [W-1:0]  x,
   output logic          locked,
   output logic          dir,
   output logic          peak,
   output logic          trough,
   output logic          err,
   output logic [7:0]    err_cnt,
   output logic [PW-1:0] period,
   output logic          period_vld
);

   localparam int            LCW       = $clog2(LOCK_N + 1);
   localparam logic [W-1:0]  MAX_VAL   = '1;
   localparam logic [W-1:0]  ZERO_VAL  = '0;
   localparam logic [LCW-1:0] LOCK_TOP = LCW'(LOCK_N);
   localparam logic [PW-1:0] SCNT_TOP  = '1;

   tri_state_t     state_q, state_d;
   logic [W-1:0]   p_q, p_d;
   logic           have_prev_q, have_prev_d;
   logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
   logic           locked_q, locked_d;
   logic           dir_q, dir_d;
   logic           peak_q, peak_d;
   logic           trough_q, trough_d;
   logic           err_q, err_d;
   logic [7:0]     err_cnt_q, err_cnt_d;
   logic [PW-1:0]  period_q, period_d;
   logic           period_vld_q, period_vld_d;
   logic [PW-1:0]  scnt_q, scnt_d;
   logic           trough_seen_q, trough_seen_d;

   tri_step_t      step;
   tri_state_t     nxt_state;
   logic           legal;
   logic           hit_peak;
   logic           hit_trough;
   logic [LCW-1:0] lock_inc;

   tri_step_classify #(.W(W)) u_classify (
      .p    (p_q),
      .s    (x),
      .step (step)
   );

   // Next state and legality of the current step, given the tracking state.
   always_comb begin
      nxt_state  = SYNC;
      legal      = 1'b0;
      hit_peak   = 1'b0;
      hit_trough = 1'b0;
      case (state_q)
         SYNC: begin
            if (step == INC) begin
               nxt_state = UP;
               legal     = 1'b1;
            end else if (step == DEC) begin
               nxt_state = DOWN;
               legal     = 1'b1;
            end else if (step == HOLD && p_q == MAX_VAL) begin
               nxt_state = HOLD_TOP;
               legal     = 1'b1;
            end else if (step == HOLD && p_q == ZERO_VAL) begin
               nxt_state = HOLD_BOT;
               legal     = 1'b1;
            end
         end
         UP: begin
            if (p_q != MAX_VAL && step == INC) begin
               nxt_state = UP;
               legal     = 1'b1;
            end else if (p_q == MAX_VAL && step == HOLD) begin
               nxt_state = HOLD_TOP;
               legal     = 1'b1;
               hit_peak  = 1'b1;
            end
         end
         HOLD_TOP: begin
            if (step == DEC) begin
               nxt_state = DOWN;
               legal     = 1'b1;
            end
         end
         DOWN: begin
            if (p_q != ZERO_VAL && step == DEC) begin
               nxt_state = DOWN;
               legal     = 1'b1;
            end else if (p_q == ZERO_VAL && step == HOLD) begin
               nxt_state  = HOLD_BOT;
               legal      = 1'b1;
               hit_trough = 1'b1;
            end
         end
         HOLD_BOT: begin
            if (step == INC) begin
               nxt_state = UP;
               legal     = 1'b1;
            end
         end
         default: begin
            nxt_state = SYNC;
         end
      endcase
   end

   // Register updates for one accepted sample: lock, error, direction, period.
   always_comb begin
      state_d       = state_q;
      p_d           = p_q;
      have_prev_d   = have_prev_q;
      lock_cnt_d    = lock_cnt_q;
      locked_d      = locked_q;
      dir_d         = dir_q;
      peak_d        = 1'b0;
      trough_d      = 1'b0;
      err_d         = 1'b0;
      err_cnt_d     = err_cnt_q;
      period_d      = period_q;
      period_vld_d  = 1'b0;
      scnt_d        = scnt_q;
      trough_seen_d = trough_seen_q;
      lock_inc      = (lock_cnt_q == LOCK_TOP) ? LOCK_TOP : lock_cnt_q + LCW'(1);

      if (en) begin
         p_d         = x;
         have_prev_d = 1'b1;
         if (have_prev_q) begin
            if (legal) begin
               state_d    = nxt_state;
               lock_cnt_d = lock_inc;
               if (lock_inc == LOCK_TOP) begin
                  locked_d = 1'b1;
               end
               if (nxt_state == UP) begin
                  dir_d = 1'b1;
               end else if (nxt_state == DOWN) begin
                  dir_d = 1'b0;
               end
               peak_d   = hit_peak;
               trough_d = hit_trough;
            end else begin
               state_d       = SYNC;
               lock_cnt_d    = '0;
               locked_d      = 1'b0;
               trough_seen_d = 1'b0;
               if (locked_q) begin
                  err_d = 1'b1;
                  if (err_cnt_q != 8'hFF) begin
                     err_cnt_d = err_cnt_q + 8'd1;
                  end
               end
            end

            // A trough can only come from a legal step, so it never races the clear above.
            if (hit_trough && legal) begin
               if (trough_seen_q) begin
                  period_d     = (scnt_q == SCNT_TOP) ? SCNT_TOP : scnt_q + PW'(1);
                  period_vld_d = 1'b1;
               end
               trough_seen_d = 1'b1;
               scnt_d        = '0;
            end else if (scnt_q != SCNT_TOP) begin
               scnt_d = scnt_q + PW'(1);
            end
         end
      end
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= SYNC;
         p_q           <= '0;
         have_prev_q   <= 1'b0;
         lock_cnt_q    <= '0;
         locked_q      <= 1'b0;
         dir_q         <= 1'b0;
         peak_q        <= 1'b0;
         trough_q      <= 1'b0;
         err_q         <= 1'b0;
         err_cnt_q     <= '0;
         period_q      <= '0;
         period_vld_q  <= 1'b0;
         scnt_q        <= '0;
         trough_seen_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         p_q           <= p_d;
         have_prev_q   <= have_prev_d;
         lock_cnt_q    <= lock_cnt_d;
         locked_q      <= locked_d;
         dir_q         <= dir_d;
         peak_q        <= peak_d;
         trough_q      <= trough_d;
         err_q         <= err_d;
         err_cnt_q     <= err_cnt_d;
         period_q      <= period_d;
         period_vld_q  <= period_vld_d;
         scnt_q        <= scnt_d;
         trough_seen_q <= trough_seen_d;
      end
   end

   assign locked     = locked_q;
   assign dir        = dir_q;
   assign peak       = peak_q;
   assign trough     = trough_q;
   assign err        = err_q;
   assign err_cnt    = err_cnt_q;
   assign period     = period_q;
   assign period_vld = period_vld_q;

endmodule

// File: tb/tb_tri_monitor.sv
// tb/tb_tri_monitor.sv - self-checking bench for tri_monitor
module tb_tri_monitor;

   localparam int W      = 4;
   localparam int LOCK_N = 4;
   localparam int PW     = 7;

   logic          clock;
   logic          reset;
   logic          en;
   logic [W-1:0]  x;
   logic          locked;
   logic          dir;
   logic          peak;
   logic          trough;
   logic          err;
   logic [7:0]    err_cnt;
   logic [PW-1:0] period;
   logic          period_vld;

   int checks = 0;
   int errors = 0;
   int ph;

   tri_monitor #(.W(W), .LOCK_N(LOCK_N), .PW(PW)) dut (
      .clock      (clock),
      .reset      (reset),
      .en         (en),
      .x          (x),
      .locked     (locked),
      .dir        (dir),
      .peak       (peak),
      .trough     (trough),
      .err        (err),
      .err_cnt    (err_cnt),
      .period     (period),
      .period_vld (period_vld)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Ideal waveform by phase: 0..15 rising, 15..0 falling, 32 samples per period.
   function automatic int tval(input int k);
      int m;
      m = k % 32;
      return (m < 16) ? m : 31 - m;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Phase-tracking model: once acquired, each sample must equal the next phase value.
   int m_have, m_p, m_track, m_ph, m_streak, m_locked, m_dir;
   int m_peak, m_trough, m_err, m_err_cnt, m_period, m_vld, m_since, m_tseen;

   always @(posedge clock or negedge reset) begin
      int xi, nph, ok, pt;
      if (!reset) begin
         m_have = 0; m_p = 0; m_track = 0; m_ph = 0; m_streak = 0; m_locked = 0;
         m_dir = 0; m_peak = 0; m_trough = 0; m_err = 0; m_err_cnt = 0;
         m_period = 0; m_vld = 0; m_since = 0; m_tseen = 0;
      end else begin
         m_peak = 0; m_trough = 0; m_err = 0; m_vld = 0;
         if (en) begin
            xi = int'(x);
            if (m_have == 0) begin
               m_have = 1;
            end else begin
               ok = 0; pt = 0;
               if (m_track != 0) begin
                  nph = (m_ph + 1) % 32;
                  if (xi == tval(nph)) begin
                     ok = 1; m_ph = nph;
                     m_peak = (nph == 16) ? 1 : 0;
                     pt = (nph == 0) ? 1 : 0;
                  end
               end else begin
                  if (xi == m_p + 1) begin ok = 1; m_ph = xi; end
                  else if (xi == m_p - 1) begin ok = 1; m_ph = 31 - xi; end
                  else if (xi == m_p && xi == 15) begin ok = 1; m_ph = 16; end
                  else if (xi == m_p && xi == 0) begin ok = 1; m_ph = 0; end
               end
               if (ok != 0) begin
                  m_track = 1;
                  m_streak++;
                  if (m_streak >= LOCK_N) m_locked = 1;
                  if (m_ph >= 1 && m_ph <= 15) m_dir = 1;
                  if (m_ph >= 17) m_dir = 0;
               end else begin
                  if (m_locked != 0) begin
                     m_err = 1;
                     m_err_cnt = (m_err_cnt < 255) ? m_err_cnt + 1 : 255;
                  end
                  m_locked = 0; m_streak = 0; m_track = 0; m_tseen = 0;
               end
               m_trough = pt;
               if (pt != 0) begin
                  if (m_tseen != 0) begin
                     m_period = (m_since + 1 < 127) ? m_since + 1 : 127;
                     m_vld = 1;
                  end
                  m_tseen = 1;
                  m_since = 0;
               end else begin
                  m_since = (m_since < 127) ? m_since + 1 : 127;
               end
            end
            m_p = xi;
         end
      end
   end

   // Every cycle, all outputs against the model.
   always @(negedge clock) begin
      chk("locked", 32'(locked), 32'(m_locked));
      chk("dir", 32'(dir), 32'(m_dir));
      chk("peak", 32'(peak), 32'(m_peak));
      chk("trough", 32'(trough), 32'(m_trough));
      chk("err", 32'(err), 32'(m_err));
      chk("err_cnt", 32'(err_cnt), 32'(m_err_cnt));
      chk("period", 32'(period), 32'(m_period));
      chk("period_vld", 32'(period_vld), 32'(m_vld));
   end

   task automatic samp(input logic e, input logic [W-1:0] v);
      en = e;
      x  = v;
      @(posedge clock);
      #1;
   endtask

   task automatic clean(input int n);
      for (int i = 0; i < n; i++) begin
         samp(1'b1, W'(tval(ph)));
         ph++;
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_locked"}, 32'(locked), 0);
      chk({tag, "_dir"}, 32'(dir), 0);
      chk({tag, "_pulses"}, 32'({peak, trough, err, period_vld}), 0);
      chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
      chk({tag, "_period"}, 32'(period), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int nv;
      reset = 1'b0;
      en    = 1'b0;
      x     = '0;
      repeat (3) @(posedge clock);
      #1;
      chk_reset_vals("rst");
      reset = 1'b1;

      // Clean stream from reset: 0,0,1..15,15,14..0,0,...
      ph = 31;
      for (int k = 0; k < 70; k++) begin
         samp(1'b1, W'(tval(ph)));
         ph++;
         if (k == 3) chk("lock_4th", 32'(locked), 0);
         if (k == 4) chk("lock_5th", 32'(locked), 1);
         if (k == 17) chk("peak_2nd15", 32'(peak), 1);
         if (k == 33) chk("trough_2nd0", 32'(trough), 1);
         if (k == 33) chk("vld_first_trough", 32'(period_vld), 0);
         if (k == 65) chk("vld_second_trough", 32'(period_vld), 1);
         if (k == 65) chk("period_32", 32'(period), 32);
      end
      chk("err_cnt_clean", 32'(err_cnt), 0);

      // Corrupted sample ...7,8,12 while locked, then relock.
      while (ph % 32 != 9) clean(1);
      samp(1'b1, 4'd12);
      chk("corrupt_err", 32'(err), 1);
      chk("corrupt_err_cnt", 32'(err_cnt), 1);
      chk("corrupt_locked", 32'(locked), 0);
      ph = 13;
      clean(3);
      chk("relock_3", 32'(locked), 0);
      clean(1);
      chk("relock_4", 32'(locked), 1);
      nv = 0;
      for (int i = 0; i < 40; i++) begin
         clean(1);
         nv += int'(period_vld);
      end
      chk("no_vld_one_trough", 32'(nv), 0);
      clean(40);

      // Direct 15->0 jump, locked then unlocked.
      while (ph % 32 != 16) clean(1);
      samp(1'b1, 4'd0);
      chk("jump_err_locked", 32'(err), 1);
      samp(1'b1, 4'd15);
      chk("jump_err_unlocked", 32'(err), 0);
      samp(1'b1, 4'd0);
      chk("jump_err_cnt", 32'(err_cnt), 2);
      ph = 32;
      clean(40);

      // en asserted one cycle in three; idle cycles carry junk on x.
      for (int i = 0; i < 70; i++) begin
         samp(1'b1, W'(tval(ph)));
         ph++;
         samp(1'b0, W'($urandom_range(15, 0)));
         samp(1'b0, W'($urandom_range(15, 0)));
      end
      chk("gap_err_cnt", 32'(err_cnt), 2);
      chk("gap_period", 32'(period), 32);

      // Missing bottom hold: ...1,0,1 while locked.
      while (ph % 32 != 0) clean(1);
      samp(1'b1, 4'd1);
      chk("nohold_err", 32'(err), 1);
      chk("nohold_trough", 32'(trough), 0);
      chk("nohold_err_cnt", 32'(err_cnt), 3);
      ph = 34;
      clean(40);

      // Reset mid-ramp on the way down.
      while (ph % 32 != 24) clean(1);
      #3;
      reset = 1'b0;
      #1;
      chk_reset_vals("async");
      @(posedge clock);
      #1;
      reset = 1'b1;
      ph = 22;
      samp(1'b1, W'(tval(ph)));
      ph++;
      chk("post_rst_first", 32'({locked, peak, trough, err, period_vld}), 0);
      clean(70);
      chk("post_rst_err_cnt", 32'(err_cnt), 0);
      chk("post_rst_period", 32'(period), 32);

      en = 1'b0;
      @(posedge clock);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
